// File: rtl/z80_bus_tracer_if.sv
// rtl/z80_bus_tracer_if.sv - tv80 pin bus plus trace record/status signals for z80_bus_tracer
interface z80_bus_tracer_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    // control
    logic             clear;

    // CPU pin bus (observed only)
    logic             m1_n;
    logic             mreq_n;
    logic             iorq_n;
    logic             rd_n;
    logic             wr_n;
    logic             rfsh_n;
    logic [15:0]      A;
    logic [7:0]       di;
    logic [7:0]       dout;

    // record stream
    logic             rec_valid;
    logic             rec_ready;
    logic [2:0]       rec_type;
    logic [15:0]      rec_addr;
    logic [7:0]       rec_data;

    // status
    logic [LW-1:0]    level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic             protocol_err;

    // environment side: drives the bus and consumes records
    modport master (
        output clear, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, rec_ready,
        input  rec_valid, rec_type, rec_addr, rec_data, level, overflow, drop_count, protocol_err
    );

    // tracer side
    modport slave (
        input  clear, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, rec_ready,
        output rec_valid, rec_type, rec_addr, rec_data, level, overflow, drop_count, protocol_err
    );
endinterface

// File: rtl/z80_bus_tracer.sv
// rtl/z80_bus_tracer.sv - passive tv80 bus-cycle classifier logging {type, addr, data} into a FIFO
module z80_bus_tracer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    z80_bus_tracer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Record type codes; T_NONE is internal only and never stored.
    localparam logic [2:0] T_FETCH = 3'd0;
    localparam logic [2:0] T_MRD   = 3'd1;
    localparam logic [2:0] T_MWR   = 3'd2;
    localparam logic [2:0] T_IORD  = 3'd3;
    localparam logic [2:0] T_IOWR  = 3'd4;
    localparam logic [2:0] T_INTA  = 3'd5;
    localparam logic [2:0] T_NONE  = 3'd6;
    localparam logic [2:0] T_ERR   = 3'd7;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    typedef struct packed {
        logic [2:0]  rtype;
        logic [15:0] addr;
        logic [7:0]  data;
    } rec_t;

    // registered bus sample
    logic             m1_n_q, mreq_n_q, iorq_n_q, rd_n_q, wr_n_q, rfsh_n_q;
    logic [15:0]      a_q;
    logic [7:0]       di_q, dout_q;
    logic             sample_valid_q;

    // capture state
    state_t           state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             armed_q, armed_d;
    logic             protocol_err_q, protocol_err_d;

    // fifo state
    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    logic [2:0]       cls;
    logic [7:0]       sample_data;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    rec_t             head;

    // Sample the pin bus; strobes reset to their inactive level so nothing looks like a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m1_n_q         <= 1'b1;
            mreq_n_q       <= 1'b1;
            iorq_n_q       <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            rfsh_n_q       <= 1'b1;
            a_q            <= '0;
            di_q           <= '0;
            dout_q         <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            m1_n_q         <= bus.m1_n;
            mreq_n_q       <= bus.mreq_n;
            iorq_n_q       <= bus.iorq_n;
            rd_n_q         <= bus.rd_n;
            wr_n_q         <= bus.wr_n;
            rfsh_n_q       <= bus.rfsh_n;
            a_q            <= bus.A;
            di_q           <= bus.di;
            dout_q         <= bus.dout;
            sample_valid_q <= 1'b1;
        end
    end

    // Classify the registered strobes in priority order; refresh always masks everything else.
    always_comb begin
        cls = T_NONE;
        if (!rfsh_n_q) begin
            cls = T_NONE;
        end else if (!mreq_n_q && !iorq_n_q) begin
            cls = T_ERR;
        end else if (!m1_n_q && !iorq_n_q) begin
            cls = T_INTA;
        end else if (!m1_n_q && !mreq_n_q && !rd_n_q) begin
            cls = T_FETCH;
        end else if (!mreq_n_q && !rd_n_q) begin
            cls = T_MRD;
        end else if (!mreq_n_q && !wr_n_q) begin
            cls = T_MWR;
        end else if (!iorq_n_q && !rd_n_q) begin
            cls = T_IORD;
        end else if (!iorq_n_q && !wr_n_q) begin
            cls = T_IOWR;
        end else if (!rd_n_q && !wr_n_q && (!mreq_n_q || !iorq_n_q)) begin
            cls = T_ERR;
        end
    end

    // Write cycles take data from the CPU, everything else from the responder.
    assign sample_data = (cls == T_MWR || cls == T_IOWR) ? dout_q : di_q;

    // Capture state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            type_q         <= T_NONE;
            addr_q         <= '0;
            data_q         <= '0;
            armed_q        <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            armed_q        <= armed_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Capture FSM: open a record on a new class, keep the latest addr/data, close on change.
    // armed stays low after reset/clear until a genuine NONE sample, so a cycle already in
    // progress at that point is never logged as a partial record.
    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        addr_d         = addr_q;
        data_d         = data_q;
        armed_d        = armed_q | (sample_valid_q & (cls == T_NONE));
        protocol_err_d = protocol_err_q | (sample_valid_q & (cls == T_ERR));
        push           = 1'b0;
        if (bus.clear) begin
            state_d        = ST_IDLE;
            armed_d        = 1'b0;
            protocol_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && cls != T_NONE) begin
                        state_d = ST_ACTIVE;
                        type_d  = cls;
                        addr_d  = a_q;
                        data_d  = sample_data;
                    end
                end
                ST_ACTIVE: begin
                    if (cls == T_NONE) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cls != type_q) begin
                        push    = 1'b1;
                        type_d  = cls;
                        addr_d  = a_q;
                        data_d  = sample_data;
                    end else begin
                        addr_d  = a_q;
                        data_d  = sample_data;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign full   = (level_q == LW'(DEPTH));
    assign pop    = bus.rec_ready && (level_q != '0) && !bus.clear;
    assign accept = push && (!full || pop);

    // FIFO storage, pointers, occupancy and drop accounting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Full with a concurrent pop still accepts: the slot being written is the one being freed.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (bus.clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = '{rtype: type_q, addr: addr_q, data: data_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (accept && !pop) begin
                level_d = level_q + LW'(1);
            end else if (!accept && pop) begin
                level_d = level_q - LW'(1);
            end
            if (push && !accept) begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.rec_valid    = (level_q != '0);
    assign bus.rec_type     = bus.rec_valid ? head.rtype : 3'd0;
    assign bus.rec_addr     = bus.rec_valid ? head.addr  : 16'd0;
    assign bus.rec_data     = bus.rec_valid ? head.data  : 8'd0;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.drop_count   = drop_count_q;
    assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_z80_bus_tracer.sv
// tb/tb_z80_bus_tracer.sv - directed and randomized bench for z80_bus_tracer
module tb_z80_bus_tracer;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] MRD   = 3'd1;
    localparam logic [2:0] MWR   = 3'd2;
    localparam logic [2:0] IORD  = 3'd3;
    localparam logic [2:0] IOWR  = 3'd4;
    localparam logic [2:0] INTA  = 3'd5;
    localparam logic [2:0] ERR   = 3'd7;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] a;
        logic [7:0]  d;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    rec_t exp_q[$];
    int   model_drops = 0;

    always #5 clk = ~clk;

    z80_bus_tracer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    z80_bus_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.rfsh_n = 1'b1;
        bus.A      = 16'($urandom);
        bus.di     = 8'($urandom);
        bus.dout   = 8'($urandom);
    endtask

    task automatic drive_strobes(input logic [2:0] t);
        idle_bus();
        case (t)
            FETCH: begin bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
            MRD:   begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
            MWR:   begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
            IORD:  begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
            IOWR:  begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
            INTA:  begin bus.m1_n = 1'b0; bus.iorq_n = 1'b0; end
            default: begin bus.mreq_n = 1'b0; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
        endcase
    endtask

    // Bus cycle of ncyc clocks; only the last clock carries the real addr/data (last sample wins).
    // Fetches are followed by a refresh cycle. The model logs the record the cycle should yield.
    task automatic txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d,
                       input int ncyc, input int gap);
        for (int i = 0; i < ncyc; i++) begin
            drive_strobes(t);
            if (i == ncyc - 1) begin
                bus.A = a;
                if (t == MWR || t == IOWR) bus.dout = d;
                else                       bus.di   = d;
            end
            tick();
        end
        if (t == FETCH) begin
            idle_bus();
            bus.rfsh_n = 1'b0;
            bus.mreq_n = 1'b0;
            tick();
        end
        for (int i = 0; i < gap; i++) begin
            idle_bus();
            tick();
        end
        if (exp_q.size() < DEPTH) exp_q.push_back('{t: t, a: a, d: d});
        else                      model_drops++;
    endtask

    task automatic settle();
        idle_bus();
        repeat (4) tick();
    endtask

    task automatic drain(input string tag);
        rec_t e;
        chk({tag, "_level"}, 32'(bus.level), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(bus.rec_valid), 32'd1);
            chk({tag, "_type"},  32'(bus.rec_type),  32'(e.t));
            chk({tag, "_addr"},  32'(bus.rec_addr),  32'(e.a));
            chk({tag, "_data"},  32'(bus.rec_data),  32'(e.d));
            bus.rec_ready = 1'b1;
            tick();
            bus.rec_ready = 1'b0;
        end
        chk({tag, "_empty_valid"}, 32'(bus.rec_valid), 32'd0);
        chk({tag, "_empty_level"}, 32'(bus.level),     32'd0);
        chk({tag, "_empty_type"},  32'(bus.rec_type),  32'd0);
        chk({tag, "_empty_addr"},  32'(bus.rec_addr),  32'd0);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        exp_q.delete();
        model_drops = 0;
    endtask

    initial begin
        logic [2:0] t;
        logic [2:0] prev_t;
        int         prev_gap;
        int         n;
        int         gap;

        reset         = 1'b1;
        bus.clear     = 1'b0;
        bus.rec_ready = 1'b0;
        idle_bus();
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_valid",    32'(bus.rec_valid),    32'd0);
        chk("rst_level",    32'(bus.level),        32'd0);
        chk("rst_overflow", 32'(bus.overflow),     32'd0);
        chk("rst_drops",    32'(bus.drop_count),   32'd0);
        chk("rst_perr",     32'(bus.protocol_err), 32'd0);
        chk("rst_type",     32'(bus.rec_type),     32'd0);
        chk("rst_data",     32'(bus.rec_data),     32'd0);

        // EX (SP),HL
        txn(FETCH, 16'h0000, 8'he3, 2, 1);
        txn(MRD,   16'h0373, 8'h8e, 3, 1);
        txn(MRD,   16'h0374, 8'he1, 3, 2);
        txn(MWR,   16'h0374, 8'h4d, 3, 1);
        txn(MWR,   16'h0373, 8'h22, 3, 1);
        settle();
        drain("ex_sp_hl");

        // OUT (0x10),A then IN A,(0x10)
        txn(IOWR, 16'h5a10, 8'h5a, 3, 1);
        txn(IORD, 16'h5a10, 8'h5a, 3, 1);
        settle();
        drain("io");

        // randomized batches, including back-to-back cycles of differing types
        for (int b = 0; b < 4; b++) begin
            n        = $urandom_range(4, 12);
            prev_t   = 3'd6;
            prev_gap = 1;
            for (int k = 0; k < n; k++) begin
                t = 3'($urandom_range(0, 6));
                if (t == 3'd6) t = ERR;
                if (prev_gap == 0 && t == prev_t) t = (t == MRD) ? MWR : MRD;
                gap = $urandom_range(0, 2);
                txn(t, 16'($urandom), 8'($urandom), $urandom_range(1, 3), gap);
                prev_t   = t;
                prev_gap = gap + ((t == FETCH) ? 1 : 0);
            end
            settle();
            drain("rand");
        end

        // overflow: DEPTH+3 records with no consumer
        for (int k = 0; k < DEPTH + 3; k++) begin
            txn((k % 2 == 0) ? MRD : MWR, 16'(16'h1000 + k), 8'(k * 7 + 1), 2, 1);
        end
        settle();
        chk("ovf_level",    32'(bus.level),      32'(DEPTH));
        chk("ovf_flag",     32'(bus.overflow),   32'd1);
        chk("ovf_drops",    32'(bus.drop_count), 32'(model_drops));
        drain("ovf");
        chk("ovf_sticky",   32'(bus.overflow),   32'd1);

        pulse_clear();
        chk("clr_overflow", 32'(bus.overflow),   32'd0);
        chk("clr_drops",    32'(bus.drop_count), 32'd0);
        chk("clr_level",    32'(bus.level),      32'd0);

        // full FIFO with a push and pop landing on the same edge
        for (int k = 0; k < DEPTH; k++) begin
            txn((k % 2 == 0) ? IORD : IOWR, 16'(16'h2000 + k), 8'(k + 8'h40), 1, 1);
        end
        settle();
        chk("fpp_full", 32'(bus.level), 32'(DEPTH));
        drive_strobes(MRD);
        bus.A  = 16'hbeef;
        bus.di = 8'h99;
        tick();
        idle_bus();
        tick();
        bus.rec_ready = 1'b1;
        tick();
        bus.rec_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back('{t: MRD, a: 16'hbeef, d: 8'h99});
        settle();
        chk("fpp_level",    32'(bus.level),    32'(DEPTH));
        chk("fpp_overflow", 32'(bus.overflow), 32'd0);
        drain("fpp");

        // protocol error held two clocks yields a single ERR record
        drive_strobes(ERR);
        bus.A  = 16'h1234;
        bus.di = 8'h77;
        tick();
        tick();
        settle();
        chk("err_level", 32'(bus.level),        32'd1);
        chk("err_type",  32'(bus.rec_type),     32'(ERR));
        chk("err_addr",  32'(bus.rec_addr),     32'h1234);
        chk("err_data",  32'(bus.rec_data),     32'h77);
        chk("err_perr",  32'(bus.protocol_err), 32'd1);
        pulse_clear();
        chk("errclr_perr",  32'(bus.protocol_err), 32'd0);
        chk("errclr_level", 32'(bus.level),        32'd0);
        chk("errclr_valid", 32'(bus.rec_valid),    32'd0);

        // reset in the middle of the MWR of EX (SP),HL
        txn(FETCH, 16'h0000, 8'he3, 2, 1);
        txn(MRD,   16'h0373, 8'h8e, 3, 1);
        txn(MRD,   16'h0374, 8'he1, 3, 2);
        drive_strobes(MWR);
        bus.A    = 16'h0374;
        bus.dout = 8'h4d;
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_q.delete();
        model_drops = 0;
        chk("mid_rst_valid", 32'(bus.rec_valid), 32'd0);
        chk("mid_rst_level", 32'(bus.level),     32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        settle();
        chk("post_rst_valid", 32'(bus.rec_valid), 32'd0);
        chk("post_rst_level", 32'(bus.level),     32'd0);
        txn(MWR, 16'h0373, 8'h22, 3, 2);
        settle();
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
